// File: rtl/snake_pkg.sv
// snake_pkg: shared constants and FSM encoding for the snake game's VGA path
package snake_pkg;
  localparam int XSCREEN = 160;
  localparam int YSCREEN = 120;
  localparam int XDIM = 10;
  localparam int YDIM = 10;
  localparam logic [2:0] BG = 3'b000;
  localparam int ADDR_W = 15;
  typedef enum logic [2:0] {IDLE, CHECK, SCAN, DRAIN, DONE} state_t;
endpackage

// File: rtl/pixel_ram.sv
// pixel_ram: simple dual-port RAM, one write port, one synchronous read port, old data on read-during-write
//   clk          clock
//   we/waddr/wdata  write port
//   raddr/rdata  read port, rdata valid one cycle after raddr
module pixel_ram #(
  parameter int DEPTH = 19200,
  parameter int AW = 15,
  parameter int DW = 3,
  parameter logic [DW-1:0] INIT = '0
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  // power-up contents are the background colour; reset never touches them
  logic [DW-1:0] mem [DEPTH] = '{default: INIT};
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/frame_occupancy_probe.sv
// frame_occupancy_probe: shadow frame buffer that reports whether a tile holds any non-background pixel
//   Clock, Resetn              clock, synchronous active-low reset
//   w_x, w_y, w_colour, w_plot pixel writes snooped from the VGA adapter path
//   q_valid, q_x, q_y, q_ready tile query handshake (top-left corner)
//   r_valid, r_hit, r_colour, r_oob  one-cycle result strobe and held result
module frame_occupancy_probe #(
  parameter int XSCREEN = snake_pkg::XSCREEN,
  parameter int YSCREEN = snake_pkg::YSCREEN,
  parameter int XDIM = snake_pkg::XDIM,
  parameter int YDIM = snake_pkg::YDIM,
  parameter logic [2:0] BG = snake_pkg::BG
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [7:0] w_x,
  input  logic [6:0] w_y,
  input  logic [2:0] w_colour,
  input  logic       w_plot,
  input  logic       q_valid,
  input  logic [7:0] q_x,
  input  logic [6:0] q_y,
  output logic       q_ready,
  output logic       r_valid,
  output logic       r_hit,
  output logic [2:0] r_colour,
  output logic       r_oob
);
  import snake_pkg::*;
  localparam int CXW = $clog2(XDIM + 1);
  localparam int CYW = $clog2(YDIM + 1);
  state_t state;
  logic [7:0] qx;
  logic [6:0] qy;
  logic [CXW-1:0] col;
  logic [CYW-1:0] row;
  logic hit, oob, rd_vld;
  logic [2:0] colour, rd_data;
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic we, accept, q_oob, issue, wrap, last;
  always_comb begin
    we = w_plot && 32'(w_x) < XSCREEN && 32'(w_y) < YSCREEN;
    w_addr = ADDR_W'(32'(w_y) * XSCREEN + 32'(w_x));
    r_addr = ADDR_W'((32'(qy) + 32'(row)) * XSCREEN + 32'(qx) + 32'(col));
    accept = q_valid && q_ready;
    // 9-bit sums so a tile hanging past the edge cannot wrap back into range
    q_oob = ({1'b0, qx} + 9'(XDIM) > 9'(XSCREEN)) || ({2'b0, qy} + 9'(YDIM) > 9'(YSCREEN));
    issue = (state == CHECK && !q_oob) || state == SCAN;
    wrap = col == CXW'(XDIM - 1);
    last = wrap && row == CYW'(YDIM - 1);
  end
  pixel_ram #(
    .DEPTH(XSCREEN * YSCREEN),
    .AW(ADDR_W),
    .DW(3),
    .INIT(BG)
  ) ram (
    .clk(Clock),
    .we(we),
    .waddr(w_addr),
    .wdata(w_colour),
    .raddr(r_addr),
    .rdata(rd_data)
  );
  // results are published on the edge that leaves DONE, together with q_ready
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
      q_ready <= 1'b0;
      r_valid <= 1'b0;
      r_hit <= 1'b0;
      r_colour <= BG;
      r_oob <= 1'b0;
      qx <= '0;
      qy <= '0;
      col <= '0;
      row <= '0;
      hit <= 1'b0;
      oob <= 1'b0;
      colour <= BG;
      rd_vld <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      rd_vld <= issue;
      if (issue) begin
        col <= wrap ? '0 : col + 1'b1;
        row <= wrap ? row + 1'b1 : row;
      end
      // only the first occupied pixel in raster order supplies the colour
      if (rd_vld && rd_data != BG) begin
        hit <= 1'b1;
        if (!hit) colour <= rd_data;
      end
      case (state)
        IDLE: begin
          q_ready <= !accept;
          if (accept) begin
            qx <= q_x;
            qy <= q_y;
            col <= '0;
            row <= '0;
            state <= CHECK;
          end
        end
        CHECK: begin
          hit <= 1'b0;
          colour <= BG;
          oob <= q_oob;
          state <= q_oob ? DONE : SCAN;
        end
        SCAN: if (last) state <= DRAIN;
        DRAIN: state <= DONE;
        DONE: begin
          state <= IDLE;
          q_ready <= 1'b1;
          r_valid <= 1'b1;
          r_hit <= hit;
          r_colour <= colour;
          r_oob <= oob;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_occupancy_probe.sv
// tb_frame_occupancy_probe: scoreboard bench for frame_occupancy_probe
module tb_frame_occupancy_probe;
  typedef struct {logic hit; logic [2:0] colour; logic oob; int lat;} exp_t;
  logic Clock = 0, Resetn = 0, w_plot = 0, q_valid = 0;
  logic [7:0] w_x = '0, q_x = '0;
  logic [6:0] w_y = '0, q_y = '0;
  logic [2:0] w_colour = '0;
  logic q_ready, r_valid, r_hit, r_oob;
  logic [2:0] r_colour;
  logic [2:0] fb [120][160];
  exp_t exp_q[$];
  int acc_q[$];
  int cyc = 0, n_acc = 0, acc_last = 0, n_res = 0, n_err = 0, n_chk = 0;
  logic prev_rv = 0;
  exp_t e, xe;
  int a, a1, n0;
  frame_occupancy_probe dut (
    .Clock(Clock), .Resetn(Resetn),
    .w_x(w_x), .w_y(w_y), .w_colour(w_colour), .w_plot(w_plot),
    .q_valid(q_valid), .q_x(q_x), .q_y(q_y), .q_ready(q_ready),
    .r_valid(r_valid), .r_hit(r_hit), .r_colour(r_colour), .r_oob(r_oob)
  );
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask
  function automatic exp_t ref_tile(input int x, input int y);
    exp_t r;
    r.hit = 0;
    r.colour = 3'b000;
    r.oob = 0;
    r.lat = 102;
    if (x + 10 > 160 || y + 10 > 120) begin
      r.oob = 1;
      r.lat = 2;
      return r;
    end
    for (int yy = y; yy < y + 10; yy++)
      for (int xx = x; xx < x + 10; xx++)
        if (!r.hit && fb[yy][xx] != 3'b000) begin
          r.hit = 1;
          r.colour = fb[yy][xx];
        end
    return r;
  endfunction
  // accepts are seen at the negedge before the edge that takes them
  always @(negedge Clock) begin
    if (Resetn && q_valid && q_ready) begin
      acc_q.push_back(cyc + 1);
      acc_last = cyc + 1;
      n_acc++;
    end
  end
  always @(negedge Clock) begin
    if (Resetn && r_valid) begin
      n_res++;
      chk("rvalid_pulse", int'(prev_rv), 0);
      if (exp_q.size() == 0 || acc_q.size() == 0) chk("spurious_rvalid", 1, 0);
      else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("r_hit", int'(r_hit), int'(e.hit));
        chk("r_colour", int'(r_colour), int'(e.colour));
        chk("r_oob", int'(r_oob), int'(e.oob));
        chk("latency", cyc - a, e.lat);
      end
    end
    prev_rv = r_valid;
  end
  task automatic tick;
    @(posedge Clock);
    #1;
  endtask
  task automatic tick_until(input int t);
    while (cyc < t) tick;
  endtask
  task automatic wr(input int x, input int y, input logic [2:0] c);
    w_x = 8'(x);
    w_y = 7'(y);
    w_colour = c;
    w_plot = 1;
    if (x < 160 && y < 120) fb[y][x] = c;
    tick;
    w_plot = 0;
  endtask
  task automatic send(input int x, input int y, input exp_t ex, input bit hold);
    int s;
    exp_q.push_back(ex);
    q_x = 8'(x);
    q_y = 7'(y);
    q_valid = 1;
    s = n_acc;
    for (int i = 0; i < 400 && n_acc == s; i++) tick;
    if (n_acc == s) chk("accept_timeout", 0, 1);
    if (!hold) q_valid = 0;
  endtask
  task automatic wait_idle;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick;
    if (exp_q.size() != 0) begin
      chk("result_timeout", exp_q.size(), 0);
      exp_q.delete();
      acc_q.delete();
    end
  endtask
  task automatic query(input int x, input int y);
    send(x, y, ref_tile(x, y), 0);
    wait_idle;
  endtask
  initial begin
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) fb[y][x] = 3'b000;
    repeat (3) tick;
    chk("rst_q_ready", int'(q_ready), 0);
    chk("rst_r_valid", int'(r_valid), 0);
    chk("rst_r_hit", int'(r_hit), 0);
    chk("rst_r_colour", int'(r_colour), 0);
    chk("rst_r_oob", int'(r_oob), 0);
    Resetn = 1;
    tick;
    chk("q_ready_after_rst", int'(q_ready), 1);
    query(39, 59);
    wr(85, 65, 3'b100);
    wr(82, 66, 3'b010);
    query(80, 60);
    repeat (4) tick;
    chk("hold_hit", int'(r_hit), 1);
    chk("hold_colour", int'(r_colour), 4);
    query(90, 60);
    wr(159, 119, 3'b011);
    query(151, 0);
    query(0, 111);
    query(150, 110);
    wr(160, 5, 3'b111);
    query(0, 0);
    xe.hit = 1;
    xe.colour = 3'b111;
    xe.oob = 0;
    xe.lat = 102;
    send(40, 60, xe, 0);
    tick_until(acc_last + 94);
    wr(49, 69, 3'b111);
    wait_idle;
    wr(49, 69, 3'b000);
    xe.hit = 0;
    xe.colour = 3'b000;
    send(40, 60, xe, 0);
    tick_until(acc_last + 99);
    wr(49, 69, 3'b111);
    wait_idle;
    query(40, 60);
    send(20, 20, ref_tile(20, 20), 1);
    a1 = acc_last;
    q_x = 8'd90;
    q_y = 7'd60;
    exp_q.push_back(ref_tile(80, 60));
    tick_until(a1 + 50);
    chk("q_ready_scan", int'(q_ready), 0);
    tick_until(a1 + 102);
    q_x = 8'd80;
    q_y = 7'd60;
    n0 = n_acc;
    for (int i = 0; i < 10 && n_acc == n0; i++) tick;
    q_valid = 0;
    chk("accept_gap", acc_last - a1, 103);
    wait_idle;
    query(80, 60);
    send(20, 20, ref_tile(20, 20), 0);
    tick_until(acc_last + 50);
    Resetn = 0;
    tick;
    tick;
    chk("abort_q_ready", int'(q_ready), 0);
    chk("abort_r_valid", int'(r_valid), 0);
    chk("abort_r_hit", int'(r_hit), 0);
    chk("abort_r_colour", int'(r_colour), 0);
    chk("abort_r_oob", int'(r_oob), 0);
    exp_q.delete();
    acc_q.delete();
    Resetn = 1;
    n0 = n_res;
    repeat (120) tick;
    chk("abort_no_rvalid", n_res - n0, 0);
    query(80, 60);
    repeat (3) tick;
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
